partition_sweep_ctrl: RTL and testbench
=======================================

PARTITION_SWEEP_CTRL -- requirements
Module: partition_sweep_ctrl

Interface
REQ-001 Parameters SHALL be: N_IN, default 7, partition input width; N_OUT, default 4, partition output width; SETTLE, default 2, settle cycles per pattern (0 allowed).
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep.
- abort  in  1  terminate a sweep.
- pi_o  out  N_IN  pattern driven to both the exact and the approximate partition.
- po_exact_i  in  N_OUT  exact partition output.
- po_approx_i  in  N_OUT  approximate partition output.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  last sweep was aborted.
- mismatch_cnt  out  N_IN+1  patterns whose outputs differ.
- ham_total  out  N_IN+$clog2(N_OUT+1)  summed bit flips.
- max_abs_err  out  N_OUT  largest |exact-approx|, outputs unsigned.

Function
REQ-003 FSM states SHALL be IDLE, SETTLE, CAPTURE, DONE.
REQ-004 IDLE with start=1 SHALL, on the next edge:
- load pi_o=0;
- clear all three metrics and aborted;
- load the settle counter with SETTLE;
- enter SETTLE, or enter CAPTURE directly when SETTLE=0.
REQ-005 SETTLE SHALL hold pi_o constant for exactly SETTLE cycles, then enter CAPTURE.
REQ-006 CAPTURE SHALL sample po_exact_i and po_approx_i in one cycle and update the metrics:
- mismatch_cnt += (exact != approx);
- ham_total += popcount(exact ^ approx);
- max_abs_err = max(max_abs_err, |exact-approx|), computed N_OUT+1 bits wide, result fits N_OUT.
REQ-007 After CAPTURE, when pi_o is not all-ones, pi_o SHALL increment by 1 and the FSM SHALL re-enter SETTLE (or CAPTURE when SETTLE=0).
REQ-008 After CAPTURE, when pi_o is all-ones, the FSM SHALL enter DONE.
REQ-009 pi_o SHALL never wrap during a sweep.
REQ-010 Each pattern SHALL take SETTLE+1 cycles.
REQ-011 For the defaults, the last CAPTURE SHALL occur 384 cycles after the start edge, and done SHALL be high in the following cycle.
REQ-012 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-013 busy SHALL be 1 in SETTLE, CAPTURE and DONE, and 0 in IDLE.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 abort in SETTLE or CAPTURE SHALL:
- discard that cycle's capture;
- set aborted=1;
- enter DONE.
REQ-016 abort in IDLE or DONE SHALL be ignored.
REQ-017 Simultaneous start and abort in IDLE: start SHALL win.
REQ-018 Metrics and aborted SHALL hold their values in IDLE until the next accepted start.
REQ-019 pi_o SHALL hold its last value after a sweep ends.

Reset
REQ-020 rst_n=0 SHALL asynchronously force:
- FSM to IDLE;
- pi_o, settle counter, all metrics, busy, done and aborted to 0.
REQ-021 Reset mid-sweep SHALL discard the partial sweep with no done pulse.
REQ-022 The first start after reset release SHALL behave per REQ-004.

Structure
REQ-023 A shared package SHALL hold:
- the FSM state enum;
- width helper functions for mismatch_cnt and ham_total.
REQ-024 The metric update SHALL live in one sub-module, sweep_err_accum, which provides clear, enable, the two output vectors and the three metric registers.

Verification
REQ-025 The bench SHALL cover these directed scenarios with the default parameters:
- approx=exact=pi_o[3:0] -> done at cycle 385; mismatch_cnt=0, ham_total=0, max_abs_err=0, aborted=0.
- approx=exact^4'b0001 -> mismatch_cnt=128, ham_total=128, max_abs_err=1.
- exact=pi_o[3:0], approx=0 -> mismatch_cnt=120, ham_total=256, max_abs_err=15.
- Assert abort during pattern 10 -> done one cycle later; aborted=1; mismatch_cnt counts only patterns 0-9 (abort-cycle capture discarded).
- Pulse start at cycle 50 of a sweep, then pull rst_n low at cycle 200 -> start ignored; all outputs 0 immediately on reset, no done pulse; a new start then runs a full 384-cycle sweep.
- SETTLE=0 -> 128 consecutive CAPTURE cycles; done at cycle 129.

Source files
------------

// File: rtl/partition_sweep_ctrl_pkg.sv
// Shared types and width helpers for the partition sweep controller.
package partition_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } sweep_state_e;

    // mismatch_cnt has to hold 2**n_in, the all-patterns-differ case
    function automatic int unsigned mismatch_cnt_w(input int unsigned n_in);
        return n_in + 32'd1;
    endfunction

    function automatic int unsigned ham_total_w(input int unsigned n_in, input int unsigned n_out);
        return n_in + 32'($clog2(n_out + 32'd1));
    endfunction

endpackage

// File: rtl/partition_sweep_ctrl_err_accum.sv
// Error metric accumulator: mismatch count, total bit flips and largest absolute error.
module sweep_err_accum
    import partition_sweep_ctrl_pkg::*;
#(
    parameter int unsigned N_IN  = 7,
    parameter int unsigned N_OUT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear_i,
    input  logic                                  en_i,
    input  logic [N_OUT-1:0]                      exact_i,
    input  logic [N_OUT-1:0]                      approx_i,
    output logic [mismatch_cnt_w(N_IN)-1:0]       mismatch_cnt_o,
    output logic [ham_total_w(N_IN, N_OUT)-1:0]   ham_total_o,
    output logic [N_OUT-1:0]                      max_abs_err_o
);

    localparam int unsigned MW = mismatch_cnt_w(N_IN);
    localparam int unsigned HW = ham_total_w(N_IN, N_OUT);
    localparam int unsigned PW = $clog2(N_OUT + 1);

    logic [MW-1:0]    mismatch_cnt_q;
    logic [HW-1:0]    ham_total_q;
    logic [N_OUT-1:0] max_abs_err_q;

    logic [N_OUT-1:0] flips_c;
    logic [PW-1:0]    pop_c;
    logic [N_OUT:0]   diff_c;
    logic [N_OUT-1:0] abs_err_c;

    // Difference is taken one bit wider so its sign bit selects the negation
    always_comb begin
        flips_c = exact_i ^ approx_i;
        pop_c   = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            pop_c = pop_c + PW'(flips_c[i]);
        end
        diff_c    = {1'b0, exact_i} - {1'b0, approx_i};
        abs_err_c = diff_c[N_OUT] ? (~diff_c[N_OUT-1:0] + 1'b1) : diff_c[N_OUT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt_q <= '0;
            ham_total_q    <= '0;
            max_abs_err_q  <= '0;
        end else if (clear_i) begin
            mismatch_cnt_q <= '0;
            ham_total_q    <= '0;
            max_abs_err_q  <= '0;
        end else if (en_i) begin
            mismatch_cnt_q <= mismatch_cnt_q + MW'(flips_c != '0);
            ham_total_q    <= ham_total_q + HW'(pop_c);
            if (abs_err_c > max_abs_err_q) begin
                max_abs_err_q <= abs_err_c;
            end
        end
    end

    assign mismatch_cnt_o = mismatch_cnt_q;
    assign ham_total_o    = ham_total_q;
    assign max_abs_err_o  = max_abs_err_q;

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive input sweep comparing an exact and an approximate partition.
module partition_sweep_ctrl
    import partition_sweep_ctrl_pkg::*;
#(
    parameter int unsigned N_IN   = 7,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    output logic [N_IN-1:0]                       pi_o,
    input  logic [N_OUT-1:0]                      po_exact_i,
    input  logic [N_OUT-1:0]                      po_approx_i,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  aborted,
    output logic [mismatch_cnt_w(N_IN)-1:0]       mismatch_cnt,
    output logic [ham_total_w(N_IN, N_OUT)-1:0]   ham_total,
    output logic [N_OUT-1:0]                      max_abs_err
);

    localparam int unsigned CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] PI_LAST = '1;
    // With no settle time every pattern goes straight to capture
    localparam sweep_state_e ST_FIRST = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] pi_q, pi_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            clear_c;
    logic            capture_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pi_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pi_q      <= pi_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pi_d      = pi_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        clear_c   = 1'b0;
        capture_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pi_d      = '0;
                    cnt_d     = CW'(SETTLE);
                    aborted_d = 1'b0;
                    clear_c   = 1'b1;
                    state_d   = ST_FIRST;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    capture_c = 1'b1;
                    if (pi_q == PI_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        pi_d    = pi_q + 1'b1;
                        cnt_d   = CW'(SETTLE);
                        state_d = ST_FIRST;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    sweep_err_accum #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_accum (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear_c),
        .en_i           (capture_c),
        .exact_i        (po_exact_i),
        .approx_i       (po_approx_i),
        .mismatch_cnt_o (mismatch_cnt),
        .ham_total_o    (ham_total),
        .max_abs_err_o  (max_abs_err)
    );

    assign pi_o    = pi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Scoreboard bench: a SETTLE=2 and a SETTLE=0 instance driven from table-based partition models.
module tb_partition_sweep_ctrl;

    typedef struct {
        int mm;
        int hm;
        int mx;
        int ab;
        int de;
        int pl;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] abort_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [1:0] ab_v;
    logic [6:0] pi_s [2];
    logic [3:0] pe_s [2];
    logic [3:0] pa_s [2];
    logic [7:0] mm_s [2];
    logic [9:0] hm_s [2];
    logic [3:0] mx_s [2];

    logic [3:0] ex_tbl [128];
    logic [3:0] ap_tbl [128];

    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t q0 [$];
    exp_t q1 [$];

    partition_sweep_ctrl #(.N_IN(7), .N_OUT(4), .SETTLE(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .pi_o(pi_s[0]), .po_exact_i(pe_s[0]), .po_approx_i(pa_s[0]),
        .busy(busy_v[0]), .done(done_v[0]), .aborted(ab_v[0]),
        .mismatch_cnt(mm_s[0]), .ham_total(hm_s[0]), .max_abs_err(mx_s[0])
    );

    partition_sweep_ctrl #(.N_IN(7), .N_OUT(4), .SETTLE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .pi_o(pi_s[1]), .po_exact_i(pe_s[1]), .po_approx_i(pa_s[1]),
        .busy(busy_v[1]), .done(done_v[1]), .aborted(ab_v[1]),
        .mismatch_cnt(mm_s[1]), .ham_total(hm_s[1]), .max_abs_err(mx_s[1])
    );

    assign pe_s[0] = ex_tbl[pi_s[0]];
    assign pa_s[0] = ap_tbl[pi_s[0]];
    assign pe_s[1] = ex_tbl[pi_s[1]];
    assign pa_s[1] = ap_tbl[pi_s[1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Metrics computed directly from the pattern tables over the patterns actually captured
    function automatic exp_t model(input int np, input int ab);
        exp_t r;
        int e, a, df;
        r = '{default: 0};
        for (int p = 0; p < np; p++) begin
            e = int'(ex_tbl[p]);
            a = int'(ap_tbl[p]);
            if (e != a) r.mm++;
            r.hm += $countones(ex_tbl[p] ^ ap_tbl[p]);
            df = (e > a) ? e - a : a - e;
            if (df > r.mx) r.mx = df;
        end
        r.ab = ab;
        r.pl = (ab != 0) ? np : 127;
        return r;
    endfunction

    function automatic void chk_outs(input int d, input exp_t e, input string tag);
        chk($sformatf("d%0d_%s_mismatch_cnt", d, tag), int'(mm_s[d]), e.mm);
        chk($sformatf("d%0d_%s_ham_total", d, tag), int'(hm_s[d]), e.hm);
        chk($sformatf("d%0d_%s_max_abs_err", d, tag), int'(mx_s[d]), e.mx);
        chk($sformatf("d%0d_%s_aborted", d, tag), int'(ab_v[d]), e.ab);
        chk($sformatf("d%0d_%s_pi", d, tag), int'(pi_s[d]), e.pl);
    endfunction

    task automatic check_done(input int d, input exp_t e);
        chk($sformatf("d%0d_done_cycle", d), cyc, e.de);
        chk($sformatf("d%0d_done_busy", d), int'(busy_v[d]), 1);
        chk_outs(d, e, "done");
    endtask

    // Monitor: every done pulse consumes exactly one expected result
    always @(negedge clk) begin
        if (rst_n && done_v[0]) begin
            if (q0.size() == 0) chk("d0_unexpected_done", int'(done_v[0]), 0);
            else check_done(0, q0.pop_front());
        end
        if (rst_n && done_v[1]) begin
            if (q1.size() == 0) chk("d1_unexpected_done", int'(done_v[1]), 0);
            else check_done(1, q1.pop_front());
        end
    end

    task automatic set_tables(input int mode);
        logic [3:0] e;
        for (int p = 0; p < 128; p++) begin
            e = 4'(p);
            case (mode)
                0: begin ex_tbl[p] = e; ap_tbl[p] = e; end
                1: begin ex_tbl[p] = e; ap_tbl[p] = e ^ 4'b0001; end
                2: begin ex_tbl[p] = e; ap_tbl[p] = 4'd0; end
                default: begin
                    ex_tbl[p] = 4'($urandom);
                    ap_tbl[p] = ($urandom_range(0, 1) == 0) ? ex_tbl[p] : (ex_tbl[p] ^ 4'($urandom));
                end
            endcase
        end
    endtask

    task automatic do_start(input int d, input bit sa, output int s);
        @(negedge clk);
        start_v[d] = 1'b1;
        abort_v[d] = sa;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        abort_v[d] = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk($sformatf("d%0d_done_timeout_pending", d), qsize(d), 0);
        if (d == 0) q0.delete();
        else q1.delete();
        chk($sformatf("d%0d_idle_busy", d), int'(busy_v[d]), 0);
        chk($sformatf("d%0d_idle_done", d), int'(done_v[d]), 0);
    endtask

    // ap < 0: full sweep; otherwise abort sampled at the off-th edge of pattern ap
    task automatic sweep(input int d, input int ap, input int off, input bit ms, input bit sa,
                         input bit dir, input int dm, input int dh, input int dx);
        int s, per, n;
        exp_t e;
        per = (d == 0) ? 3 : 1;
        do_start(d, sa, s);
        if (ap >= 0) begin
            e    = model(ap, 1);
            e.de = s + per * ap + off;
        end else begin
            e    = model(128, 0);
            e.de = s + per * 128;
        end
        if (dir) begin
            e.mm = dm;
            e.hm = dh;
            e.mx = dx;
        end
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        if (ms) begin
            repeat (49) @(posedge clk);
            @(negedge clk);
            start_v[d] = 1'b1;
            @(posedge clk);
            #1 start_v[d] = 1'b0;
        end
        if (ap >= 0) begin
            n = per * ap + off - 1;
            repeat (n) @(posedge clk);
            @(negedge clk);
            abort_v[d] = 1'b1;
            @(posedge clk);
            #1 abort_v[d] = 1'b0;
        end
        wait_done(d);
        @(negedge clk);
        abort_v[d] = 1'b1;
        @(posedge clk);
        #1 abort_v[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs(d, e, "hold");
        chk($sformatf("d%0d_hold_busy", d), int'(busy_v[d]), 0);
    endtask

    initial begin
        exp_t z;
        int   s, d, ap, off;
        bit   ms, sa;
        z       = '{default: 0};
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        start_v = '0;
        abort_v = '0;
        set_tables(0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_outs(i, z, "reset");
            chk($sformatf("d%0d_reset_busy", i), int'(busy_v[i]), 0);
            chk($sformatf("d%0d_reset_done", i), int'(done_v[i]), 0);
        end
        rst_n = 1'b1;

        set_tables(0);
        sweep(0, -1, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        set_tables(1);
        sweep(0, -1, 0, 1'b0, 1'b0, 1'b1, 128, 128, 1);
        set_tables(2);
        sweep(0, -1, 0, 1'b0, 1'b0, 1'b1, 120, 256, 15);
        sweep(0, 10, 2, 1'b0, 1'b0, 1'b1, 9, 15, 9);
        sweep(0, 10, 3, 1'b0, 1'b0, 1'b1, 9, 15, 9);

        // Ignored start at cycle 50, then reset at cycle 200 of the sweep
        set_tables(3);
        do_start(0, 1'b0, s);
        repeat (49) @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (148) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outs(0, z, "midrst");
        chk("d0_midrst_busy", int'(busy_v[0]), 0);
        chk("d0_midrst_done", int'(done_v[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep(0, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        set_tables(3);
        sweep(1, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        sweep(0, -1, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0);

        for (int it = 0; it < 8; it++) begin
            d   = int'($urandom_range(0, 1));
            ap  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 127));
            off = (d == 0) ? int'($urandom_range(1, 3)) : 1;
            ms  = (d == 0 && ap < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            sa  = 1'($urandom_range(0, 1));
            set_tables(3);
            sweep(d, ap, off, ms, sa, 1'b0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
